// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: state encoding and counter sizing.
package rst_seq_pkg;

    typedef enum logic [2:0] {
        ST_RST     = 3'd0,
        ST_STABLE  = 3'd1,
        ST_RELEASE = 3'd2,
        ST_GAP     = 3'd3,
        ST_RUN     = 3'd4,
        ST_HOLD    = 3'd5
    } seq_state_e;

    // One spare bit above the largest terminal count so a saturated counter never aliases.
    function automatic int unsigned cnt_width(
        input int unsigned a,
        input int unsigned b,
        input int unsigned c,
        input int unsigned d
    );
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer, parameterised width, asynchronous active-low reset to 0.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rst_sequencer.sv
// Power-on / soft-reset sequencer: releases per-stage resets in order, each gated
// by the stage's init-done (or a timeout), with a soft-reset path that keeps lock.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int unsigned N_STAGE      = 3,
    parameter int unsigned STABLE_CYC   = 1000,
    parameter int unsigned STAGE_GAP    = 16,
    parameter int unsigned DONE_TIMEOUT = 100000,
    parameter int unsigned SOFT_HOLD    = 32
) (
    input  logic               sys_clk100m,
    input  logic               sys_rstn,
    input  logic               soft_rst_req,
    input  logic [N_STAGE-1:0] stage_done,
    output logic [N_STAGE-1:0] stage_rstn,
    output logic               all_ready,
    output logic [N_STAGE-1:0] timeout_err,
    output logic [2:0]         seq_state
);

    localparam int unsigned CNT_W = cnt_width(STABLE_CYC, STAGE_GAP, DONE_TIMEOUT, SOFT_HOLD);
    localparam int unsigned K_W   = (N_STAGE > 1) ? $clog2(N_STAGE) : 1;

    // The cycle spent in RST after the synchronizer releases is the first clean
    // cycle, so STABLE itself only needs STABLE_CYC-1 more.
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'((STABLE_CYC > 2) ? STABLE_CYC - 2 : 0);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'((STAGE_GAP > 1) ? STAGE_GAP - 1 : 0);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'((DONE_TIMEOUT > 1) ? DONE_TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'((SOFT_HOLD > 1) ? SOFT_HOLD - 1 : 0);
    localparam logic [CNT_W-1:0] FLUSH_CYC   = CNT_W'(2);
    localparam logic [K_W-1:0]   K_LAST      = K_W'(N_STAGE - 1);

    logic               rst_int_n;
    logic [N_STAGE-1:0] done_s;

    sync_2ff #(.WIDTH(1)) u_rst_sync (
        .clk   (sys_clk100m),
        .rst_n (sys_rstn),
        .d     (1'b1),
        .q     (rst_int_n)
    );

    sync_2ff #(.WIDTH(N_STAGE)) u_done_sync (
        .clk   (sys_clk100m),
        .rst_n (sys_rstn),
        .d     (stage_done),
        .q     (done_s)
    );

    seq_state_e         state_q, state_d;
    logic [K_W-1:0]     k_q, k_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_STAGE-1:0] stage_rstn_q, stage_rstn_d;
    logic [N_STAGE-1:0] err_q, err_d;
    logic               all_ready_q, all_ready_d;
    logic               advance;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        err_d   = err_q;
        advance = 1'b0;

        case (state_q)
            ST_RST: begin
                if (rst_int_n) state_d = ST_STABLE;
            end
            ST_STABLE: begin
                if (soft_rst_req) begin
                    state_d = ST_HOLD;
                end else if (cnt_q >= STABLE_LAST) begin
                    state_d = ST_RELEASE;
                    k_d     = '0;
                end
            end
            ST_RELEASE: begin
                // Done wins over a coincident timeout; a timeout still flags even if soft reset wins.
                if ((cnt_q >= FLUSH_CYC) && done_s[k_q]) begin
                    advance = 1'b1;
                end else if (cnt_q == TO_LAST) begin
                    advance    = 1'b1;
                    err_d[k_q] = 1'b1;
                end
                if (soft_rst_req) begin
                    state_d = ST_HOLD;
                end else if (advance) begin
                    state_d = (k_q == K_LAST) ? ST_RUN : ST_GAP;
                end
            end
            ST_GAP: begin
                if (soft_rst_req) begin
                    state_d = ST_HOLD;
                end else if (cnt_q >= GAP_LAST) begin
                    state_d = ST_RELEASE;
                    k_d     = k_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (soft_rst_req) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (cnt_q >= HOLD_LAST) begin
                    state_d = ST_RELEASE;
                    k_d     = '0;
                end
            end
            default: state_d = ST_RST;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end

        // Registered outputs are derived from the next state so they change on the entry edge.
        stage_rstn_d = '0;
        for (int unsigned i = 0; i < N_STAGE; i++) begin
            stage_rstn_d[i] = (state_d == ST_RUN) ||
                              (((state_d == ST_RELEASE) || (state_d == ST_GAP)) && (K_W'(i) <= k_d));
        end
        all_ready_d = (state_d == ST_RUN);
    end

    always_ff @(posedge sys_clk100m or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_q      <= ST_RST;
            k_q          <= '0;
            cnt_q        <= '0;
            stage_rstn_q <= '0;
            err_q        <= '0;
            all_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            cnt_q        <= cnt_d;
            stage_rstn_q <= stage_rstn_d;
            err_q        <= err_d;
            all_ready_q  <= all_ready_d;
        end
    end

    assign stage_rstn  = stage_rstn_q;
    assign all_ready   = all_ready_q;
    assign timeout_err = err_q;
    assign seq_state   = state_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Scoreboard bench for rst_sequencer: stimulus queues expected output events
// (edge number plus output values); a monitor pops one per observed output change.
module tb_rst_sequencer;
    import rst_seq_pkg::*;

    localparam int unsigned NS = 3;

    logic          sys_clk100m  = 1'b0;
    logic          sys_rstn     = 1'b1;
    logic          soft_rst_req = 1'b0;
    logic [NS-1:0] stage_done   = '0;
    logic [NS-1:0] stage_rstn;
    logic          all_ready;
    logic [NS-1:0] timeout_err;
    logic [2:0]    seq_state;

    logic clk_en = 1'b1;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    event probe_ev;

    typedef struct {
        int       cyc;
        logic [2:0] st;
        logic [2:0] stg;
        logic       ar;
        logic [2:0] err;
    } exp_t;

    exp_t exp_q[$];

    rst_sequencer #(
        .N_STAGE      (NS),
        .STABLE_CYC   (8),
        .STAGE_GAP    (4),
        .DONE_TIMEOUT (20),
        .SOFT_HOLD    (6)
    ) dut (
        .sys_clk100m  (sys_clk100m),
        .sys_rstn     (sys_rstn),
        .soft_rst_req (soft_rst_req),
        .stage_done   (stage_done),
        .stage_rstn   (stage_rstn),
        .all_ready    (all_ready),
        .timeout_err  (timeout_err),
        .seq_state    (seq_state)
    );

    // Gated so the asynchronous reset path can be exercised with no clock at all.
    initial forever begin
        #5;
        if (clk_en) sys_clk100m = ~sys_clk100m;
    end

    always @(posedge sys_clk100m) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp_v);
        end
    endtask

    task automatic push(input int c, input seq_state_e s, input logic [2:0] stg,
                        input logic ar, input logic [2:0] err);
        exp_t e;
        e.cyc = c;
        e.st  = s;
        e.stg = stg;
        e.ar  = ar;
        e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic at_cycle(input int n);
        while (cyc < n) @(negedge sys_clk100m);
    endtask

    task automatic release_rst(output int base);
        @(negedge sys_clk100m);
        sys_rstn = 1'b1;
        base     = cyc;
    endtask

    task automatic drop_rst();
        push(cyc, ST_RST, 3'b000, 1'b0, 3'b000);
        sys_rstn   = 1'b0;
        stage_done = '0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(seq_state or stage_rstn or all_ready or timeout_err or probe_ev);
            #1;
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event cyc=%0d got state=%0d stage_rstn=%b all_ready=%b timeout_err=%b exp none",
                             cyc, seq_state, stage_rstn, all_ready, timeout_err);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_cycle", 32'(cyc), 32'(e.cyc));
                    chk("seq_state", 32'(seq_state), 32'(e.st));
                    chk("stage_rstn", 32'(stage_rstn), 32'(e.stg));
                    chk("all_ready", 32'(all_ready), 32'(e.ar));
                    chk("timeout_err", 32'(timeout_err), 32'(e.err));
                end
            end
        end
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int b;
        int s;
        #2 sys_rstn = 1'b0;
        repeat (3) @(negedge sys_clk100m);
        mon_en = 1'b1;
        push(cyc, ST_RST, 3'b000, 1'b0, 3'b000);
        ->probe_ev;
        @(negedge sys_clk100m);

        // Power-up, each done raised 5 cycles after its stage is released.
        release_rst(b);
        push(b + 3,  ST_STABLE,  3'b000, 1'b0, 3'b000);
        push(b + 10, ST_RELEASE, 3'b001, 1'b0, 3'b000);
        at_cycle(b + 15); stage_done[0] = 1'b1;
        push(b + 18, ST_GAP,     3'b001, 1'b0, 3'b000);
        push(b + 22, ST_RELEASE, 3'b011, 1'b0, 3'b000);
        at_cycle(b + 19); stage_done[0] = 1'b0;
        at_cycle(b + 27); stage_done[1] = 1'b1;
        push(b + 30, ST_GAP,     3'b011, 1'b0, 3'b000);
        push(b + 34, ST_RELEASE, 3'b111, 1'b0, 3'b000);
        at_cycle(b + 31); stage_done[1] = 1'b0;
        at_cycle(b + 39); stage_done[2] = 1'b1;
        push(b + 42, ST_RUN,     3'b111, 1'b1, 3'b000);
        at_cycle(b + 43); stage_done[2] = 1'b0;
        at_cycle(b + 46); drop_rst();
        at_cycle(b + 50);

        // Stage 1 never reports done: timeout at 20 cycles into RELEASE(1).
        release_rst(b);
        push(b + 3,  ST_STABLE,  3'b000, 1'b0, 3'b000);
        push(b + 10, ST_RELEASE, 3'b001, 1'b0, 3'b000);
        at_cycle(b + 15); stage_done[0] = 1'b1;
        push(b + 18, ST_GAP,     3'b001, 1'b0, 3'b000);
        push(b + 22, ST_RELEASE, 3'b011, 1'b0, 3'b000);
        push(b + 42, ST_GAP,     3'b011, 1'b0, 3'b010);
        push(b + 46, ST_RELEASE, 3'b111, 1'b0, 3'b010);
        at_cycle(b + 51); stage_done[2] = 1'b1;
        push(b + 54, ST_RUN,     3'b111, 1'b1, 3'b010);

        // Soft reset in RUN with all dones already high: flush window paces each stage.
        at_cycle(b + 56); stage_done = 3'b111;
        at_cycle(b + 60);
        s = cyc;
        soft_rst_req = 1'b1;
        push(s + 1,  ST_HOLD,    3'b000, 1'b0, 3'b010);
        push(s + 7,  ST_RELEASE, 3'b001, 1'b0, 3'b010);
        push(s + 10, ST_GAP,     3'b001, 1'b0, 3'b010);
        push(s + 14, ST_RELEASE, 3'b011, 1'b0, 3'b010);
        push(s + 17, ST_GAP,     3'b011, 1'b0, 3'b010);
        push(s + 21, ST_RELEASE, 3'b111, 1'b0, 3'b010);
        push(s + 24, ST_RUN,     3'b111, 1'b1, 3'b010);
        at_cycle(s + 1); soft_rst_req = 1'b0;
        at_cycle(s + 3); soft_rst_req = 1'b1;
        at_cycle(s + 4); soft_rst_req = 1'b0;
        at_cycle(s + 28); drop_rst();
        at_cycle(s + 32);

        // Lock loss during GAP(1) with the clock stopped.
        release_rst(b);
        push(b + 3,  ST_STABLE,  3'b000, 1'b0, 3'b000);
        push(b + 10, ST_RELEASE, 3'b001, 1'b0, 3'b000);
        at_cycle(b + 15); stage_done[0] = 1'b1;
        push(b + 18, ST_GAP,     3'b001, 1'b0, 3'b000);
        push(b + 22, ST_RELEASE, 3'b011, 1'b0, 3'b000);
        at_cycle(b + 27); stage_done[1] = 1'b1;
        push(b + 30, ST_GAP,     3'b011, 1'b0, 3'b000);
        at_cycle(b + 31);
        clk_en = 1'b0;
        drop_rst();
        #23;
        clk_en = 1'b1;
        at_cycle(b + 34);

        // Restart through STABLE; soft request in RST is ignored; soft wins over last done.
        release_rst(b);
        push(b + 3,  ST_STABLE,  3'b000, 1'b0, 3'b000);
        push(b + 10, ST_RELEASE, 3'b001, 1'b0, 3'b000);
        at_cycle(b + 1); soft_rst_req = 1'b1;
        at_cycle(b + 2); soft_rst_req = 1'b0;
        at_cycle(b + 15); stage_done[0] = 1'b1;
        push(b + 18, ST_GAP,     3'b001, 1'b0, 3'b000);
        push(b + 22, ST_RELEASE, 3'b011, 1'b0, 3'b000);
        at_cycle(b + 27); stage_done[1] = 1'b1;
        push(b + 30, ST_GAP,     3'b011, 1'b0, 3'b000);
        push(b + 34, ST_RELEASE, 3'b111, 1'b0, 3'b000);
        at_cycle(b + 39); stage_done[2] = 1'b1;
        at_cycle(b + 41); soft_rst_req = 1'b1;
        push(b + 42, ST_HOLD,    3'b000, 1'b0, 3'b000);
        push(b + 48, ST_RELEASE, 3'b001, 1'b0, 3'b000);
        push(b + 51, ST_GAP,     3'b001, 1'b0, 3'b000);
        push(b + 55, ST_RELEASE, 3'b011, 1'b0, 3'b000);
        push(b + 58, ST_GAP,     3'b011, 1'b0, 3'b000);
        push(b + 62, ST_RELEASE, 3'b111, 1'b0, 3'b000);
        push(b + 65, ST_RUN,     3'b111, 1'b1, 3'b000);
        at_cycle(b + 42); soft_rst_req = 1'b0;
        at_cycle(b + 72);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events got=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
